// File: rtl/rv_branch_pkg.sv
// Shared opcode/funct3 encodings and BHT counter helpers for the branch
// resolution path.
package rv_branch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef logic [1:0] bht_ctr_t;

  // Two-bit saturating counter step: up on taken, down on not-taken.
  function automatic bht_ctr_t ctr_next(input bht_ctr_t ctr, input logic taken);
    if (taken)
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else
      return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_bht.sv
// Direct-mapped bimodal history table: one combinational lookup port for
// fetch and one training port written at the resolve accept edge.
module branch_bht
  import rv_branch_pkg::*;
#(
  parameter int       BHT_DEPTH = 64,
  parameter int       IDX_W     = $clog2(BHT_DEPTH),
  parameter bht_ctr_t CTR_INIT  = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_taken,
  input  logic             train_en,
  input  logic [IDX_W-1:0] train_idx,
  input  logic             train_taken
);

  bht_ctr_t ctr [BHT_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) ctr[i] <= CTR_INIT;
    end else if (train_en) begin
      ctr[train_idx] <= ctr_next(ctr[train_idx], train_taken);
    end
  end

  // Lookup reads the stored array, so a same-cycle train is not forwarded.
  assign lookup_taken = ctr[lookup_idx][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution with a single registered output stage, bimodal
// predictor training and a saturating mispredict counter.
module branch_resolve_unit
  import rv_branch_pkg::*;
#(
  parameter int         XLEN      = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CTR_INIT  = 2'b01,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rdata1,
  input  logic [XLEN-1:0]  rdata2,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  lookup_pc,
  output logic             lookup_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             br_taken,
  output logic [XLEN-1:0]  br_target,
  output logic [XLEN-1:0]  link_addr,
  output logic             mispredict,
  output logic             illegal,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  logic                    accept;
  logic signed [XLEN-1:0]  rs1_s;
  logic signed [XLEN-1:0]  rs2_s;
  logic                    taken_c;
  logic                    illegal_c;
  logic                    train_c;
  logic                    mispred_c;
  logic [XLEN-1:0]         link_c;
  logic [XLEN-1:0]         jump_c;
  logic [XLEN-1:0]         target_c;

  logic                    vld_p1;
  logic                    taken_p1;
  logic                    mispred_p1;
  logic                    illegal_p1;
  logic [XLEN-1:0]         target_p1;
  logic [XLEN-1:0]         link_p1;
  logic [CNT_W-1:0]        cnt_p1;
  logic                    unused_lookup_bits;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;
  assign rs1_s    = rdata1;
  assign rs2_s    = rdata2;

  always_comb begin
    link_c    = pc + XLEN'(4);
    jump_c    = pc + imm;
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    train_c   = 1'b0;
    target_c  = link_c;
    case (opcode)
      OP_BRANCH: begin
        train_c = 1'b1;
        case (funct3)
          F3_BEQ:  taken_c = (rs1_s == rs2_s);
          F3_BNE:  taken_c = (rs1_s != rs2_s);
          F3_BLT:  taken_c = (rs1_s < rs2_s);
          F3_BGE:  taken_c = (rs1_s >= rs2_s);
          F3_BLTU: taken_c = (rdata1 < rdata2);
          F3_BGEU: taken_c = (rdata1 >= rdata2);
          default: begin
            illegal_c = 1'b1;
            train_c   = 1'b0;
          end
        endcase
        if (taken_c) target_c = jump_c;
      end
      OP_JAL: begin
        taken_c  = 1'b1;
        target_c = jump_c;
      end
      OP_JALR: begin
        taken_c  = 1'b1;
        target_c = (rdata1 + imm) & ~XLEN'(1);
      end
      default: ;
    endcase
  end

  assign mispred_c = taken_c ^ pred_taken;

  branch_bht #(
    .BHT_DEPTH (BHT_DEPTH),
    .IDX_W     (IDX_W),
    .CTR_INIT  (CTR_INIT)
  ) u_bht (
    .clk          (clk),
    .rst          (rst),
    .lookup_idx   (lookup_pc[IDX_W+1:2]),
    .lookup_taken (lookup_taken),
    .train_en     (accept && train_c),
    .train_idx    (pc[IDX_W+1:2]),
    .train_taken  (taken_c)
  );

  assign unused_lookup_bits = ^{lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

  // Output stage p1: result held until the consumer drains it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1     <= 1'b0;
      taken_p1   <= 1'b0;
      mispred_p1 <= 1'b0;
      illegal_p1 <= 1'b0;
      target_p1  <= '0;
      link_p1    <= '0;
      cnt_p1     <= '0;
    end else if (accept) begin
      vld_p1     <= 1'b1;
      taken_p1   <= taken_c;
      mispred_p1 <= mispred_c;
      illegal_p1 <= illegal_c;
      target_p1  <= target_c;
      link_p1    <= link_c;
      if (mispred_c) cnt_p1 <= cnt_sat_inc(cnt_p1);
    end else if (out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign out_valid      = vld_p1;
  assign br_taken       = taken_p1;
  assign br_target      = target_p1;
  assign link_addr      = link_p1;
  assign mispredict     = mispred_p1;
  assign illegal        = illegal_p1;
  assign mispredict_cnt = cnt_p1;

endmodule
